fifo_stream_drain: RTL and testbench

- Read-side consumer placed directly downstream of the team's synchronous FIFO.
- Issues `fifo_rd_en` against the FIFO's `empty` flag and absorbs the FIFO's 1-cycle registered `data_out` latency.
- Presents the words as a valid/ready stream with full throughput, through a 3-entry output buffer.
- By construction it never provokes FIFO underflow. It also keeps a transfer counter and a sticky error flag for the verification environment.

---
 rtl/fifo_stream_drain.sv | 117 +++++++++++
 tb/tb_fifo_stream_drain.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_drain
// Description : Read-side consumer for a synchronous FIFO. It issues reads
//               against the empty flag and absorbs the FIFO's 1-cycle
//               registered read latency. Words are presented as a valid/ready
//               stream through a 3-entry buffer. Also keeps a transfer counter
//               and a sticky underflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  err_underflow,
  output logic                  idle
);

  // Highest buffer index; pointers wrap from here back to 0.
  localparam logic [1:0] c_LAST_IDX = 2'd2;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] buf_q [0:2];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [2:0]            w_pending;
  logic                  w_push;
  logic                  w_pop;

  // Words already committed to the buffer: stored ones plus the one returning.
  assign w_pending = {1'b0, occ_q} + {2'b00, inflight_q};

  // A read is issued only when a slot is guaranteed for the returning word;
  // deliberately independent of m_ready so no combinational path exists.
  assign fifo_rd_en = !rst && en && !fifo_empty && (w_pending <= 3'd2);

  assign w_push = inflight_q;
  assign w_pop  = m_valid && m_ready;

  assign m_valid       = (occ_q != 2'd0);
  assign m_data        = buf_q[rd_ptr_q];
  assign word_cnt      = cnt_q;
  assign err_underflow = err_q;
  assign idle          = (occ_q == 2'd0) && !inflight_q && fifo_empty;

  // Next-state for pointers, occupancy, transfer counter and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    err_d    = err_q | fifo_underflow;
    if (w_push) begin
      wr_ptr_d = (wr_ptr_q == c_LAST_IDX) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == c_LAST_IDX) ? 2'd0 : rd_ptr_q + 2'd1;
      cnt_d    = cnt_q + c_CNT_ONE;
    end
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      if (w_push) begin
        buf_q[wr_ptr_q] <= fifo_data_out;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // A returning word must never arrive at a full buffer that is not draining.
  always_ff @(posedge clk) begin
    if (!rst && w_push && !w_pop) begin
      assert (occ_q != 2'd3)
      else $error("fifo_stream_drain: buffer overflow, occ would exceed 3");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_drain
// Description : Self-checking bench for fifo_stream_drain with a FIFO model,
//               a count-based stream model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_drain;

  localparam int DW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          fifo_underflow = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_cnt;
  logic          err_underflow;
  logic          idle;

  // Upstream FIFO model storage
  logic [DW-1:0] fifo_mem [0:63];
  int            wr_idx = 0;
  int            rd_idx = 0;

  int n_tests = 0;
  int n_fail  = 0;

  assign fifo_empty = (rd_idx == wr_idx);

  fifo_stream_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en    (fifo_rd_en),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .word_cnt      (word_cnt),
    .err_underflow (err_underflow),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  // FIFO with registered read data, one cycle after the read request
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data_out <= fifo_mem[rd_idx];
      rd_idx        <= rd_idx + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: counts of reads issued and words delivered
  logic [DW-1:0] exp_q [$];
  int            n_iss = 0;
  int            n_iss_old = 0;
  int            n_del = 0;
  bit            err_seen = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      check("rd_en_in_reset", fifo_rd_en, 0);
      n_iss = 0;
      n_iss_old = 0;
      n_del = 0;
      exp_q.delete();
      err_seen = 0;
      prev_stall = 0;
    end else begin
      bit e_rd;
      bit e_valid;
      int pend;
      pend    = n_iss - n_del;
      e_rd    = en && !fifo_empty && (pend <= 2);
      e_valid = (n_iss_old - n_del) > 0;
      check("rd_en", fifo_rd_en, e_rd);
      check("m_valid", m_valid, e_valid);
      check("word_cnt", word_cnt, n_del);
      check("idle", idle, (pend == 0) && fifo_empty);
      check("err_underflow", err_underflow, err_seen);
      if (prev_stall) check("hold_data", m_data, prev_data);
      if (fifo_rd_en) exp_q.push_back(fifo_mem[rd_idx]);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("m_valid_extra", m_valid, 0);
        else check("m_data", m_data, exp_q.pop_front());
        n_del++;
      end
      n_iss_old = n_iss;
      if (fifo_rd_en) n_iss++;
      if (fifo_underflow) err_seen = 1;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_mem[wr_idx] = v;
    wr_idx++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Directed scenarios
  initial begin
    int rd_cnt;
    tick;
    check("reset_valid", m_valid, 0);
    check("reset_cnt", word_cnt, 0);
    check("reset_err", err_underflow, 0);
    check("reset_data", m_data, 0);
    tick;
    rst = 1'b0;

    // Preload 1..4, full-throughput drain
    for (int k = 1; k <= 4; k++) push(k[DW-1:0]);
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t1_rd", fifo_rd_en, i < 4);
      if (i >= 2 && i <= 5) begin
        check("t1_valid", m_valid, 1);
        check("t1_data", m_data, i - 1);
      end
      tick;
    end
    #1;
    check("t1_cnt", word_cnt, 4);
    check("t1_idle", idle, 1);

    // Backpressure: 8 words, stalled sink
    m_ready = 1'b0;
    for (int k = 0; k < 8; k++) push(16'h0100 + k[DW-1:0]);
    rd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (fifo_rd_en) rd_cnt++;
      tick;
    end
    #1;
    check("t2_reads", rd_cnt, 3);
    check("t2_valid", m_valid, 1);
    check("t2_head", m_data, 16'h0100);
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick;
    #1;
    check("t2_cnt", word_cnt, 12);
    check("t2_idle", idle, 1);

    // Alternating ready with 10 words
    for (int k = 0; k < 10; k++) push(16'h0200 + k[DW-1:0]);
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2 == 0);
      tick;
    end
    m_ready = 1'b1;
    tick;
    #1;
    check("t3_cnt", word_cnt, 22);
    check("t3_err", err_underflow, 0);

    // en dropped right after a single read issue
    en = 1'b0;
    for (int k = 0; k < 5; k++) push(16'h0300 + k[DW-1:0]);
    #1;
    check("t4_rd_off", fifo_rd_en, 0);
    tick;
    en = 1'b1;
    #1;
    check("t4_rd_on", fifo_rd_en, 1);
    tick;
    en = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (fifo_rd_en) rd_cnt++;
      tick;
    end
    #1;
    check("t4_reads", rd_cnt, 0);
    check("t4_cnt", word_cnt, 23);
    check("t4_drained", m_valid, 0);
    check("t4_not_idle", idle, 0);

    // Reset with two buffered words and one in flight
    m_ready = 1'b0;
    en = 1'b1;
    tick;
    tick;
    tick;
    #1;
    check("t5_pre_rd", fifo_rd_en, 0);
    check("t5_pre_valid", m_valid, 1);
    check("t5_pre_data", m_data, 16'h0301);
    rst = 1'b1;
    en = 1'b0;
    tick;
    rst = 1'b0;
    m_ready = 1'b1;
    #1;
    check("t5_valid", m_valid, 0);
    check("t5_cnt", word_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      #1;
      check("t5_stale", m_valid, 0);
    end

    // Sticky underflow flag
    fifo_underflow = 1'b1;
    tick;
    fifo_underflow = 1'b0;
    #1;
    check("t6_err_set", err_underflow, 1);
    tick;
    tick;
    #1;
    check("t6_err_sticky", err_underflow, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check("t6_err_clr", err_underflow, 0);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
